// File: rtl/jtframe_sdram_sched_pkg.sv
// jtframe_sdram_sched_pkg
// Shared types and constants for the SDRAM request scheduler:
//   state_t      - scheduler FSM states (IDLE, ISSUE, WAIT)
//   NBANK        - number of game bank request ports
//   OWN_PROG     - owner code of the ROM-download port (banks use 0..3)
//   owner_onehot - owner code to {prog, bank3..bank0} one-hot vector
package jtframe_sdram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int NBANK = 4;
    localparam logic [2:0] OWN_PROG = 3'd4;

    function automatic logic [NBANK:0] owner_onehot(input logic [2:0] owner);
        owner_onehot = (NBANK+1)'(1) << owner;
    endfunction

endpackage

// File: rtl/jtframe_sdram_sched_if.sv
// jtframe_sdram_sched_if
// Single-command bus between the scheduler and the SDRAM engine.
//   cmd_vld/cmd_rdy   - command handshake (accepted when both high)
//   cmd_ba/cmd_addr   - target bank and word address
//   cmd_wr            - 1 = write
//   cmd_din/cmd_dsn   - write data and active-low byte strobes
//   cmd_done/cmd_dout - one-cycle completion pulse and read data
// Modports: master = scheduler side, slave = engine side.
interface jtframe_sdram_sched_if #(
    parameter int SDRAMW = 22
);
    logic              cmd_vld;
    logic              cmd_rdy;
    logic [1:0]        cmd_ba;
    logic [SDRAMW-1:0] cmd_addr;
    logic              cmd_wr;
    logic [15:0]       cmd_din;
    logic [1:0]        cmd_dsn;
    logic              cmd_done;
    logic [15:0]       cmd_dout;

    modport master (
        output cmd_vld, cmd_ba, cmd_addr, cmd_wr, cmd_din, cmd_dsn,
        input  cmd_rdy, cmd_done, cmd_dout
    );

    modport slave (
        input  cmd_vld, cmd_ba, cmd_addr, cmd_wr, cmd_din, cmd_dsn,
        output cmd_rdy, cmd_done, cmd_dout
    );
endinterface

// File: rtl/jtframe_rr_arb.sv
// jtframe_rr_arb
// Purely combinational 4-way round-robin picker.
//   req - request vector, one bit per bank
//   ptr - bank with highest priority this round
//   gnt - one-hot grant: first requesting bank at or after ptr (mod 4)
//   vld - at least one request present
module jtframe_rr_arb (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       vld
);
    logic [1:0] idx;

    // Scan from the farthest offset back to the pointer so the closest
    // requester at or after ptr is the last, and therefore winning, write.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/jtframe_sdram_sched.sv
// jtframe_sdram_sched
// Scheduler between four game bank ports plus the ROM-download (prog) port
// and a single-command SDRAM engine. One command outstanding at a time;
// banks are served round-robin, prog has exclusive access while prog_en=1.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ba_addr/rd/wr/din/dsn - packed bank requests (bank n in slice n)
//   ba_ack, ba_rdy      - per-bank accept / completion pulses
//   prog_*              - download port requests, prog_ack/prog_rdy pulses
//   dout                - read data of the last completed read
//   cmd                 - engine bus (jtframe_sdram_sched_if.master)
//   err                 - sticky watchdog flag
// Macro JTFRAME_SDRAM_SCHED_WDOG_EN enables the WAIT-state watchdog
// (TOUT cycles); without it err is tied 0 and WAIT has no time limit.
module jtframe_sdram_sched
    import jtframe_sdram_sched_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter int TOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*SDRAMW-1:0]   ba_addr,
    input  logic [3:0]            ba_rd,
    input  logic [3:0]            ba_wr,
    input  logic [63:0]           ba_din,
    input  logic [7:0]            ba_dsn,
    output logic [3:0]            ba_ack,
    output logic [3:0]            ba_rdy,
    input  logic                  prog_en,
    input  logic [SDRAMW-1:0]     prog_addr,
    input  logic [1:0]            prog_ba,
    input  logic                  prog_rd,
    input  logic                  prog_we,
    input  logic [15:0]           prog_data,
    input  logic [1:0]            prog_mask,
    output logic                  prog_ack,
    output logic                  prog_rdy,
    output logic [15:0]           dout,
    jtframe_sdram_sched_if.master cmd,
    output logic                  err
);
    state_t            state_reg, state_next;
    logic [1:0]        ptr_reg, ptr_next;
    logic [2:0]        owner_reg, owner_next;
    logic [1:0]        ba_reg, ba_next;
    logic [SDRAMW-1:0] addr_reg, addr_next;
    logic              wr_reg, wr_next;
    logic [15:0]       din_reg, din_next;
    logic [1:0]        dsn_reg, dsn_next;
    logic [NBANK:0]    rdy_reg, rdy_next;
    logic [15:0]       dout_reg, dout_next;
`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
    logic [7:0]        cnt_reg, cnt_next;
    logic              err_reg, err_next;
`endif

    logic [NBANK-1:0]  gnt;
    logic              gnt_vld;
    logic              accept;

    jtframe_rr_arb u_arb (
        .req (ba_rd | ba_wr),
        .ptr (ptr_reg),
        .gnt (gnt),
        .vld (gnt_vld)
    );

    assign accept = (state_reg == ISSUE) && cmd.cmd_rdy;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        ba_next    = ba_reg;
        addr_next  = addr_reg;
        wr_next    = wr_reg;
        din_next   = din_reg;
        dsn_next   = dsn_reg;
        rdy_next   = '0;
        dout_next  = dout_reg;
`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (prog_en) begin
                    // Download owns the bus: bank requests are not looked at.
                    if (prog_rd | prog_we) begin
                        state_next = ISSUE;
                        owner_next = OWN_PROG;
                        ba_next    = prog_ba;
                        addr_next  = prog_addr;
                        wr_next    = prog_we;
                        din_next   = prog_data;
                        dsn_next   = prog_mask;
                    end
                end else if (gnt_vld) begin
                    state_next = ISSUE;
                    for (int i = 0; i < NBANK; i++) begin
                        if (gnt[i]) begin
                            owner_next = 3'(i);
                            ba_next    = 2'(i);
                            addr_next  = ba_addr[i*SDRAMW +: SDRAMW];
                            wr_next    = ba_wr[i];
                            din_next   = ba_din[i*16 +: 16];
                            dsn_next   = ba_dsn[i*2 +: 2];
                            ptr_next   = 2'(i + 1);
                        end
                    end
                end
            end
            ISSUE: begin
                if (cmd.cmd_rdy) begin
                    state_next = WAIT;
`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
                    cnt_next   = '0;
`endif
                end
            end
            WAIT: begin
                if (cmd.cmd_done) begin
                    state_next = IDLE;
                    rdy_next   = owner_onehot(owner_reg);
                    if (!wr_reg) dout_next = cmd.cmd_dout;
                end
`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
                // The count reaches TOUT on this edge: give up, release the
                // owner with a rdy pulse and leave dout untouched.
                else if (cnt_reg == 8'(TOUT - 1)) begin
                    state_next = IDLE;
                    rdy_next   = owner_onehot(owner_reg);
                    err_next   = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + 8'd1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            ba_reg    <= '0;
            addr_reg  <= '0;
            wr_reg    <= 1'b0;
            din_reg   <= '0;
            dsn_reg   <= 2'b11;
            rdy_reg   <= '0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            ba_reg    <= ba_next;
            addr_reg  <= addr_next;
            wr_reg    <= wr_next;
            din_reg   <= din_next;
            dsn_reg   <= dsn_next;
            rdy_reg   <= rdy_next;
            dout_reg  <= dout_next;
        end
    end

`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Ack is combinational so it lands in the very cycle the engine accepts.
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
        assign ba_ack[gi] = accept && (owner_reg == 3'(gi));
        assign ba_rdy[gi] = rdy_reg[gi];
    end
    assign prog_ack = accept && (owner_reg == OWN_PROG);
    assign prog_rdy = rdy_reg[NBANK];

    assign dout         = dout_reg;
    assign cmd.cmd_vld  = (state_reg == ISSUE);
    assign cmd.cmd_ba   = ba_reg;
    assign cmd.cmd_addr = addr_reg;
    assign cmd.cmd_wr   = wr_reg;
    assign cmd.cmd_din  = din_reg;
    assign cmd.cmd_dsn  = dsn_reg;

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// tb_jtframe_sdram_sched
// Directed bench for jtframe_sdram_sched with a transaction-level model.
// Inputs change 2 time units after a rising edge; the monitor samples
// everything on the falling edge. Watchdog scenario runs only when
// JTFRAME_SDRAM_SCHED_WDOG_EN is defined.
module tb_jtframe_sdram_sched;
    localparam int SDRAMW = 22;
    localparam int TOUT   = 255;
`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4*SDRAMW-1:0] ba_addr;
    logic [3:0]  ba_rd, ba_wr, ba_ack, ba_rdy;
    logic [63:0] ba_din;
    logic [7:0]  ba_dsn;
    logic        prog_en, prog_rd, prog_we, prog_ack, prog_rdy;
    logic [SDRAMW-1:0] prog_addr;
    logic [1:0]  prog_ba, prog_mask;
    logic [15:0] prog_data, dout;
    logic        err;

    jtframe_sdram_sched_if #(.SDRAMW(SDRAMW)) cmd_bus ();

    jtframe_sdram_sched #(.SDRAMW(SDRAMW), .TOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_dsn(ba_dsn),
        .ba_ack(ba_ack), .ba_rdy(ba_rdy),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd),
        .prog_we(prog_we), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .dout(dout), .cmd(cmd_bus), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Engine: accepts, then pulses cmd_done after eng_lat cycles with eng_data.
    logic        eng_hang = 1'b0;
    int          eng_lat = 5;
    logic [15:0] eng_data = 16'hBEEF;

    initial begin
        cmd_bus.cmd_done = 1'b0;
        cmd_bus.cmd_dout = '0;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_bus.cmd_vld && cmd_bus.cmd_rdy && !eng_hang) begin
                repeat (eng_lat) @(posedge clk);
                #2;
                cmd_bus.cmd_done = 1'b1;
                cmd_bus.cmd_dout = eng_data;
                eng_data = eng_data + 16'h0111;
                @(posedge clk);
                #2;
                cmd_bus.cmd_done = 1'b0;
            end
        end
    end

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < 4; k++)
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    // Observation log and transaction-level model.
    int glog[$];
    int cyc = 0, rdy_cnt = 0, ack_cyc = 0, rdy_cyc = 0;
    logic [SDRAMW-1:0] ack_addr;
    logic        ack_wr;
    logic [15:0] ack_din;
    logic [1:0]  ack_dsn, ack_ba;

    bit m_have, m_acc, m_rdy_pend, m_err;
    int m_owner, m_ptr, wcnt;
    logic [1:0]  m_ba, m_dsn;
    logic [SDRAMW-1:0] m_addr;
    logic        m_wr;
    logic [15:0] m_din, m_dout;

    always @(negedge clk) begin : monitor
        logic [4:0] act_ack, act_rdy, exp_ack, oh;
        int g;
        cyc++;
        act_ack = {prog_ack, ba_ack};
        act_rdy = {prog_rdy, ba_rdy};
        if (!rst_n) begin
            chk("rst_cmd_vld", cmd_bus.cmd_vld, 0);
            chk("rst_ack", act_ack, 0);
            chk("rst_rdy", act_rdy, 0);
            chk("rst_dout", dout, 0);
            chk("rst_err", err, 0);
            chk("rst_cmd_dsn", cmd_bus.cmd_dsn, 2'b11);
            chk("rst_cmd_fields", {cmd_bus.cmd_ba, cmd_bus.cmd_addr, cmd_bus.cmd_wr, cmd_bus.cmd_din}, 0);
            m_have = 0; m_acc = 0; m_rdy_pend = 0; m_err = 0;
            m_ptr = 0; m_dout = '0; wcnt = 0; m_owner = 0;
        end else begin
            oh = 5'b1 << m_owner;
            if (act_ack != 0) begin
                for (int k = 0; k < 5; k++) if (act_ack[k]) glog.push_back(k);
                ack_cyc = cyc;
                ack_addr = cmd_bus.cmd_addr; ack_wr = cmd_bus.cmd_wr;
                ack_din = cmd_bus.cmd_din; ack_dsn = cmd_bus.cmd_dsn; ack_ba = cmd_bus.cmd_ba;
            end
            if (act_rdy != 0) begin rdy_cnt++; rdy_cyc = cyc; end

            chk("rdy", act_rdy, m_rdy_pend ? oh : 5'b0);
            if (m_rdy_pend) begin m_rdy_pend = 0; m_have = 0; m_acc = 0; end
            chk("dout", dout, m_dout);
            chk("err", err, m_err);

            exp_ack = (m_have && !m_acc && cmd_bus.cmd_rdy) ? oh : 5'b0;
            chk("cmd_vld", cmd_bus.cmd_vld, m_have && !m_acc);
            chk("ack", act_ack, exp_ack);
            if (m_have) begin
                chk("cmd_ba", cmd_bus.cmd_ba, m_ba);
                chk("cmd_addr", cmd_bus.cmd_addr, m_addr);
                chk("cmd_wr", cmd_bus.cmd_wr, m_wr);
                chk("cmd_din", cmd_bus.cmd_din, m_din);
                chk("cmd_dsn", cmd_bus.cmd_dsn, m_dsn);
            end

            if (exp_ack != 0) begin
                m_acc = 1; wcnt = 0;
            end else if (m_acc) begin
                wcnt++;
                if (cmd_bus.cmd_done) begin
                    m_rdy_pend = 1;
                    if (!m_wr) m_dout = cmd_bus.cmd_dout;
                end else if (WDOG && wcnt == TOUT) begin
                    m_rdy_pend = 1;
                    m_err = 1;
                end
            end

            if (!m_have) begin
                if (prog_en) begin
                    if (prog_rd || prog_we) begin
                        m_have = 1; m_owner = 4; m_ba = prog_ba; m_addr = prog_addr;
                        m_wr = prog_we; m_din = prog_data; m_dsn = prog_mask;
                    end
                end else begin
                    g = rr_pick(ba_rd | ba_wr, m_ptr);
                    if (g >= 0) begin
                        m_have = 1; m_owner = g; m_ba = 2'(g);
                        m_addr = ba_addr[g*SDRAMW +: SDRAMW];
                        m_wr = ba_wr[g]; m_din = ba_din[g*16 +: 16]; m_dsn = ba_dsn[g*2 +: 2];
                        m_ptr = (g + 1) % 4;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int t = 0;
        while (glog.size() < n && t < budget) begin @(negedge clk); #1; t++; end
        chk(name, glog.size() >= n, 1);
    endtask

    task automatic wait_rdy(input int n, input int budget, input string name);
        int t = 0;
        while (rdy_cnt < n && t < budget) begin @(negedge clk); #1; t++; end
        chk(name, rdy_cnt >= n, 1);
    endtask

    function automatic int glog_at(input int i);
        if (i < 0 || i >= glog.size()) return -1;
        return glog[i];
    endfunction

    initial begin : stim
        int base, rbase, rise_cyc;
        ba_addr   = {22'h3_0C0C, 22'h2_0B0B, 22'h1_0A0A, 22'h00_1234};
        ba_din    = {16'h4444, 16'h2222, 16'h00FF, 16'h1111};
        ba_dsn    = 8'b00_01_10_11;
        ba_rd = '0; ba_wr = '0;
        prog_en = 0; prog_addr = '0; prog_ba = '0; prog_rd = 0; prog_we = 0;
        prog_data = '0; prog_mask = 2'b11;
        cmd_bus.cmd_rdy = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Single read from bank 0
        step();
        cmd_bus.cmd_rdy = 1'b1;
        ba_rd = 4'b0001;
        wait_acks(1, 20, "t1_ack_timeout");
        step();
        ba_rd = '0;
        wait_rdy(1, 40, "t1_rdy_timeout");
        chk("t1_owner", glog_at(0), 0);
        chk("t1_addr", ack_addr, 22'h1234);
        chk("t1_wr", ack_wr, 0);
        chk("t1_dout", dout, 16'hBEEF);
        chk("t1_latency", rdy_cyc - ack_cyc, 6);

        // Round-robin from a fresh pointer
        step(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        glog.delete();
        rbase = rdy_cnt;
        eng_data = 16'h1000;
        ba_rd = 4'b1111;
        wait_acks(5, 80, "rr_ack_timeout");
        step();
        ba_rd = '0;
        wait_rdy(rbase + 5, 40, "rr_rdy_timeout");
        chk("rr_g0", glog_at(0), 0);
        chk("rr_g1", glog_at(1), 1);
        chk("rr_g2", glog_at(2), 2);
        chk("rr_g3", glog_at(3), 3);
        chk("rr_g4", glog_at(4), 0);
        chk("rr_dout", dout, 16'h1444);

        // Prog exclusivity
        step();
        base = glog.size(); rbase = rdy_cnt;
        prog_en = 1; prog_we = 1; prog_ba = 2'd2; prog_addr = 22'h2A_BCDE;
        prog_data = 16'hA55A; prog_mask = 2'b00; ba_rd = 4'b0011;
        wait_acks(base + 1, 20, "prog_ack_timeout");
        step();
        prog_we = 0;
        wait_rdy(rbase + 1, 40, "prog_rdy_timeout");
        repeat (6) step();
        chk("prog_nacks", glog.size(), base + 1);
        chk("prog_owner", glog_at(base), 4);
        chk("prog_ba", ack_ba, 2);
        chk("prog_wr", ack_wr, 1);
        chk("prog_din", ack_din, 16'hA55A);
        ba_rd = '0; prog_en = 0;

        // Back-pressure on bank 2
        step();
        base = glog.size();
        cmd_bus.cmd_rdy = 1'b0;
        ba_rd = 4'b0100;
        repeat (10) step();
        @(negedge clk); #1;
        chk("bp_vld_held", cmd_bus.cmd_vld, 1);
        chk("bp_no_ack", glog.size(), base);
        step();
        cmd_bus.cmd_rdy = 1'b1;
        rise_cyc = cyc + 1;
        wait_acks(base + 1, 10, "bp_ack_timeout");
        chk("bp_ack_cycle", ack_cyc, rise_cyc);
        chk("bp_owner", glog_at(base), 2);
        chk("bp_addr", ack_addr, 22'h2_0B0B);
        step();
        ba_rd = '0;
        wait_rdy(rdy_cnt + 1, 40, "bp_rdy_timeout");

        // Read+write collision on bank 1
        step();
        base = glog.size(); rbase = rdy_cnt;
        ba_rd = 4'b0010; ba_wr = 4'b0010;
        wait_acks(base + 1, 20, "col_ack_timeout");
        step();
        ba_rd = '0; ba_wr = '0;
        wait_rdy(rbase + 1, 40, "col_rdy_timeout");
        chk("col_owner", glog_at(base), 1);
        chk("col_wr", ack_wr, 1);
        chk("col_din", ack_din, 16'h00FF);
        chk("col_dsn", ack_dsn, 2'b10);

        // Reset while waiting on the engine
        step();
        base = glog.size();
        eng_hang = 1'b1;
        ba_rd = 4'b1000;
        wait_acks(base + 1, 20, "rstw_ack_timeout");
        step();
        ba_rd = '0;
        step();
        rst_n = 1'b0;
        rbase = rdy_cnt;
        @(negedge clk); #1;
        chk("rstw_vld", cmd_bus.cmd_vld, 0);
        chk("rstw_dout", dout, 0);
        step();
        rst_n = 1'b1;
        eng_hang = 1'b0;
        repeat (8) step();
        chk("rstw_no_rdy", rdy_cnt, rbase);

`ifdef JTFRAME_SDRAM_SCHED_WDOG_EN
        // Watchdog: engine never answers
        step();
        base = glog.size(); rbase = rdy_cnt;
        eng_hang = 1'b1;
        ba_rd = 4'b0001;
        wait_acks(base + 1, 20, "wd_ack_timeout");
        step();
        ba_rd = '0;
        wait_rdy(rbase + 1, 400, "wd_rdy_timeout");
        chk("wd_latency", rdy_cyc - ack_cyc, 256);
        chk("wd_err", err, 1);
        step();
        eng_hang = 1'b0;
        repeat (4) step();
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
